// File: rtl/program_loader_if.sv
// Byte-stream link into the loader plus the CPU instruction-fetch path.
interface program_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] pc_addr;
   logic [15:0] instruction;

   // master: byte producer / CPU side; slave: the loader.
   modport master (
      output rx_data,
      output rx_valid,
      output pc_addr,
      input  rx_ready,
      input  instruction
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  pc_addr,
      output rx_ready,
      output instruction
   );
endinterface

// File: rtl/program_loader.sv
// Loads a framed, XOR-checksummed image of big-endian 16-bit words into instruction RAM.
// Fetch is combinational; rx_ready is low outside a load so the producer holds its byte.
module program_loader #(
   parameter int          MEM_SIZE  = 32,
   parameter logic [15:0] FILL_WORD = 16'hC000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   program_loader_if.slave     lif,
   output logic                cpu_rst,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [15:0]         words_loaded
);

   localparam int          AW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam logic [15:0] MEM_W = 16'(MEM_SIZE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  acc_q, acc_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] len_q, len_d;
   logic [15:0] words_q, words_d;

   logic        rx_ready;
   logic        accept;
   logic        wr_en;
   logic [15:0] wr_dat;
   logic [15:0] len_full;

   logic [15:0] mem [MEM_SIZE];

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      len_d    = len_q;
      words_d  = words_q;
      rx_ready = 1'b0;
      wr_en    = 1'b0;
      wr_dat   = {hi_q, lif.rx_data};
      len_full = {len_q[15:8], lif.rx_data};

      case (state_q)
         S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: rx_ready = 1'b1;
         default:                                           rx_ready = 1'b0;
      endcase
      accept = rx_ready && lif.rx_valid;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN_HI;
               acc_d   = 8'h00;
               words_d = 16'h0000;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = lif.rx_data;
               acc_d       = acc_q ^ lif.rx_data;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d   = len_full;
               acc_d   = acc_q ^ lif.rx_data;
               words_d = 16'h0000;
               if (len_full == 16'h0000 || len_full > MEM_W) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_DATA_HI;
               end
            end
         end
         S_DATA_HI: begin
            if (accept) begin
               hi_d    = lif.rx_data;
               acc_d   = acc_q ^ lif.rx_data;
               state_d = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (accept) begin
               // words_q doubles as the RAM write pointer.
               wr_en   = 1'b1;
               acc_d   = acc_q ^ lif.rx_data;
               words_d = words_q + 16'd1;
               state_d = (words_d == len_q) ? S_CHECK : S_DATA_HI;
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = (lif.rx_data == acc_q) ? S_DONE : S_ERROR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= 8'h00;
         hi_q    <= 8'h00;
         len_q   <= 16'h0000;
         words_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         len_q   <= len_d;
         words_q <= words_d;
      end
   end

   // RAM has no reset so a failed or interrupted load keeps what it wrote.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[words_q[AW-1:0]] <= wr_dat;
      end
   end

   always_comb begin
      if (lif.pc_addr < MEM_W) begin
         lif.instruction = mem[lif.pc_addr[AW-1:0]];
      end else begin
         lif.instruction = FILL_WORD;
      end
   end

   assign lif.rx_ready  = rx_ready;
   assign busy          = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
   assign done          = (state_q == S_DONE);
   assign error         = (state_q == S_ERROR);
   assign cpu_rst       = (state_q != S_DONE);
   assign words_loaded  = words_q;

endmodule
